// File: rtl/cam_cfg_seq.sv
// Camera configuration sequencer.
// Walks the configuration ROM from address 0. Each 16-bit entry is one of three things:
//   - a {register, value} write, forwarded to the SCCB master over valid/ready,
//   - a millisecond delay (hi = FF),
//   - an end marker (FFFF).
// A write of bit 7 to register 0x12 is a sensor soft reset. It is followed by a forced
// RESET_DELAY_MS wait before the next ROM entry is fetched.
// Ports:
//   i_clk, i_rstn (synchronous, active-low), i_start (one-cycle start pulse)
//   o_rom_addr / i_rom_data : ROM with one-cycle registered read
//   o_sccb_valid / i_sccb_ready, o_sccb_id/reg/data : write request to the SCCB master
//   o_busy, o_done, o_wr_count : pass status and count of accepted writes (saturating)
module cam_cfg_seq #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned RESET_DELAY_MS = 1,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  input  logic        i_sccb_ready,
  output logic [7:0]  o_sccb_id,
  output logic [7:0]  o_sccb_reg,
  output logic [7:0]  o_sccb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_wr_count
);

  // Guard against a clock slower than 1 kHz: treat one millisecond as at least one cycle.
  localparam int unsigned MS_CYC_RAW = CLK_FREQ / 1000;
  localparam int unsigned MS_CYC     = (MS_CYC_RAW == 0) ? 1 : MS_CYC_RAW;
  localparam int          PRE_W      = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(MS_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
  localparam logic [15:0]      RST_MS     = 16'(RESET_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_REQ,
    S_WAIT_IDLE,
    S_DELAY,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_rom_addr;
  logic             r_sccb_valid;
  logic [7:0]       r_sccb_reg;
  logic [7:0]       r_sccb_data;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_wr_count;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [15:0]      r_ms_cnt;
  logic             r_rst_pend;
  logic             r_seen_low;

  logic [7:0] w_hi;
  logic [7:0] w_lo;
  logic       w_is_end;
  logic       w_is_delay;
  logic       w_is_softrst;

  assign w_hi         = i_rom_data[15:8];
  assign w_lo         = i_rom_data[7:0];
  assign w_is_end     = (i_rom_data == 16'hFFFF);
  assign w_is_delay   = (w_hi == 8'hFF) && (w_lo != 8'hFF);
  assign w_is_softrst = (w_hi == 8'h12) && w_lo[7];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_rom_addr   <= 8'd0;
      r_sccb_valid <= 1'b0;
      r_sccb_reg   <= 8'd0;
      r_sccb_data  <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_count   <= 8'd0;
      r_pre_cnt    <= '0;
      r_ms_cnt     <= 16'd0;
      r_rst_pend   <= 1'b0;
      r_seen_low   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_rom_addr <= 8'd0;
            r_wr_count <= 8'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
          end
        end

        // The ROM read needs one cycle after the address changes.
        S_FETCH: r_state <= S_LATCH;

        S_LATCH: begin
          if (w_is_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else if (w_is_delay) begin
            if (w_lo == 8'd0) begin
              r_state <= S_NEXT;
            end else begin
              r_ms_cnt  <= {8'd0, w_lo};
              r_pre_cnt <= PRE_RELOAD;
              r_state   <= S_DELAY;
            end
          end else begin
            r_sccb_reg   <= w_hi;
            r_sccb_data  <= w_lo;
            r_sccb_valid <= 1'b1;
            r_rst_pend   <= w_is_softrst;
            r_state      <= S_REQ;
          end
        end

        S_REQ: begin
          if (i_sccb_ready) begin
            r_sccb_valid <= 1'b0;
            r_seen_low   <= 1'b0;
            if (r_wr_count != 8'hFF) r_wr_count <= r_wr_count + 8'd1;
            r_state <= S_WAIT_IDLE;
          end
        end

        // The master is still idle-looking right after acceptance. A write has only
        // finished once ready has been seen low and then high again.
        S_WAIT_IDLE: begin
          if (!i_sccb_ready) begin
            r_seen_low <= 1'b1;
          end else if (r_seen_low) begin
            r_rst_pend <= 1'b0;
            if (r_rst_pend && (RST_MS != 16'd0)) begin
              r_ms_cnt  <= RST_MS;
              r_pre_cnt <= PRE_RELOAD;
              r_state   <= S_DELAY;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end

        // The prescaler runs MS_CYC cycles per millisecond. Exit happens on the last
        // cycle of the last millisecond, so the state lasts exactly ms * MS_CYC cycles.
        S_DELAY: begin
          if (r_pre_cnt == '0) begin
            if (r_ms_cnt <= 16'd1) begin
              r_ms_cnt <= 16'd0;
              r_state  <= S_NEXT;
            end else begin
              r_ms_cnt  <= r_ms_cnt - 16'd1;
              r_pre_cnt <= PRE_RELOAD;
            end
          end else begin
            r_pre_cnt <= r_pre_cnt - PRE_ONE;
          end
        end

        S_NEXT: begin
          if (r_rom_addr == 8'hFF) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_rom_addr <= r_rom_addr + 8'd1;
            r_state    <= S_FETCH;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_valid = r_sccb_valid;
  assign o_sccb_id    = SLAVE_ADDR;
  assign o_sccb_reg   = r_sccb_reg;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_wr_count   = r_wr_count;

endmodule

// File: doc/cam_cfg_seq.md
# cam_cfg_seq

Camera configuration sequencer. It walks the configuration ROM from address 0, decodes each 16-bit entry as a {register, value} write, a millisecond delay or an end marker, and feeds register writes to the SCCB master over a valid/ready handshake. It sits between the configuration ROM (1-cycle registered read) and the SCCB master inside the camera interface. It signals completion so the capture path can be enabled.

## Interface

Parameters:
- CLK_FREQ, 25_000_000: i_clk frequency in Hz. One millisecond equals CLK_FREQ/1000 cycles (integer division).
- RESET_DELAY_MS, 1: forced delay after a soft-reset write (register 0x12 with value bit 7 set).
- SLAVE_ADDR, 8'h42: SCCB write ID, driven on o_sccb_id.

Ports:
- i_clk, in, 1: clock.
- i_rstn, in, 1: reset, synchronous, active-low. Clock is i_clk.
- i_start, in, 1: single-cycle pulse that starts a configuration pass.
- o_rom_addr, out, 8: ROM address.
- i_rom_data, in, 16: ROM data. It is valid on the second edge after o_rom_addr changes.
- o_sccb_valid, out, 1: write request to the SCCB master.
- i_sccb_ready, in, 1: high when the SCCB master is idle and accepting requests.
- o_sccb_id, out, 8: constant SLAVE_ADDR.
- o_sccb_reg, out, 8: register address of the current write.
- o_sccb_data, out, 8: register value of the current write.
- o_busy, out, 1: a configuration pass is in progress.
- o_done, out, 1: the pass completed. Held high until the next start or reset.
- o_wr_count, out, 8: number of writes accepted in the current pass. Saturates at 255.

## Operation

Entry decode (hi = i_rom_data[15:8], lo = i_rom_data[7:0]):
- 16'hFFFF: end marker. Go to DONE.
- hi = 8'hFF, lo ≠ 8'hFF: delay of lo milliseconds. lo = 0 means no delay.
- Any other value: write lo to register hi. If hi = 8'h12 and lo[7] = 1, run an extra RESET_DELAY_MS delay after the write completes.

States:
- IDLE: o_busy = 0. On i_start, set o_rom_addr = 0, o_wr_count = 0, o_done = 0, o_busy = 1, then go to FETCH.
- FETCH: one wait cycle, then go to LATCH.
- LATCH: capture i_rom_data and decode it. Go to DONE, DELAY or REQ.
- REQ: drive o_sccb_valid = 1 with reg and data stable. On the edge where valid and ready are both high, drop valid, increment o_wr_count, and go to WAIT_IDLE.
- WAIT_IDLE: wait for i_sccb_ready to go low and then high again, meaning the write has finished. Then go to DELAY if a reset delay is pending, otherwise go to NEXT.
- DELAY: a millisecond prescaler (CLK_FREQ/1000 cycles) decrements the ms counter. At 0, go to NEXT.
- NEXT: if o_rom_addr = 255, go to DONE (no wrap). Otherwise increment o_rom_addr and go to FETCH.
- DONE: o_done = 1, o_busy = 0. i_start restarts the pass as from IDLE.

Rules:
- i_start is ignored while o_busy = 1.
- o_sccb_reg and o_sccb_data change only in LATCH. They hold their value otherwise.
- If a ready drop is not seen within one cycle of acceptance, WAIT_IDLE still requires observing ready low before it exits.

## Timing

- Reset values: o_rom_addr 0, o_sccb_valid 0, o_sccb_reg 0, o_sccb_data 0, o_busy 0, o_done 0, o_wr_count 0, state IDLE, both counters 0. o_sccb_id is always SLAVE_ADDR.
- Start to first o_sccb_valid: 3 cycles (IDLE → FETCH → LATCH → REQ).
- With ready stuck high, acceptance happens in the first REQ cycle.
- Per-entry overhead with no delay: NEXT + FETCH + LATCH = 3 cycles, plus REQ and WAIT_IDLE time.
- A delay of N ms lasts exactly N × (CLK_FREQ/1000) cycles in DELAY.
- Reset mid-pass, including during REQ or DELAY: all outputs return to reset values on the same edge. No further request is issued until the next i_start.

## Test plan

The bench uses a model ROM with 1-cycle read latency, CLK_FREQ = 10_000 (10 cycles per ms), and an SCCB model that drops ready for 8 cycles after each acceptance.

- ROM {12_80, 11_80, FFFF}, pulse i_start. Expect write (12,80), then 10 cycles of DELAY after ready returns, then write (11,80). Expect o_done = 1 and o_wr_count = 2. o_sccb_id = 42 throughout.
- ROM {11_01, FF_03, 0C_00, FFFF}. Expect exactly 30 DELAY cycles between ready recovery after write 1 and o_rom_addr advancing. Expect o_wr_count = 2.
- Backpressure: hold ready low for 5 cycles while valid is high. Expect valid held, reg and data unchanged, o_rom_addr unchanged. Acceptance happens on the first ready-high edge.
- ROM address 0 = FFFF. Expect o_done within 3 cycles of i_start, no o_sccb_valid pulse, o_wr_count = 0.
- Assert reset during a FF_05 delay. Expect all outputs at reset values on the next edge. A new i_start refetches address 0. A pulse on i_start mid-pass has no effect on address or count.
- ROM with no end marker (all entries 01_00). Expect 256 writes, o_rom_addr stops at 255, o_done = 1, o_wr_count saturates at 255.
